rib_rr_arbiter: RTL and testbench

RIB_RR_ARBITER -- requirements
Module: rib_rr_arbiter

---
 rtl/rib_rr_arbiter_if.sv | 20 ++
 rtl/rib_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_rib_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rib_rr_arbiter_if.sv
// rtl/rib_rr_arbiter_if.sv - request/grant bundle between masters and rib_rr_arbiter
interface rib_rr_arbiter_if;
   logic [3:0] req_i;
   logic [1:0] grant_o;
   logic       grant_valid_o;
   logic [3:0] grant_onehot_o;
   logic       hold_flag_o;
   logic       timeout_o;
   logic [7:0] timeout_cnt_o;

   modport master (
      output req_i,
      input  grant_o, grant_valid_o, grant_onehot_o, hold_flag_o, timeout_o, timeout_cnt_o
   );

   modport slave (
      input  req_i,
      output grant_o, grant_valid_o, grant_onehot_o, hold_flag_o, timeout_o, timeout_cnt_o
   );
endinterface

// File: rtl/rib_rr_arbiter.sv
// rtl/rib_rr_arbiter.sv - 4-master round-robin arbiter with master-3 priority
// Define RIB_ARB_TIMEOUT_EN to force re-arbitration after MAX_HOLD grant cycles.
module rib_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter bit          PRIO_M3  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   rib_rr_arbiter_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_grant, w_grant_nxt;
   logic       r_valid, w_valid_nxt;
   logic [3:0] r_onehot, w_onehot_nxt;
   logic [1:0] r_last_ptr, w_last_ptr_nxt;
   logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
   logic       r_timeout, w_timeout_nxt;
   logic [7:0] r_timeout_cnt, w_timeout_cnt_nxt;

   logic [3:0] w_others;
   logic [3:0] w_cand;
   logic [1:0] w_sel;
   logic       w_owner_req;
   logic       w_force;

   assign w_owner_req = bus.req_i[r_grant];
   assign w_others    = bus.req_i & ~r_onehot;
   // In GRANT the owner is masked so a forced re-arbitration never picks it again.
   assign w_cand      = (r_state == GRANT) ? w_others : bus.req_i;

`ifdef RIB_ARB_TIMEOUT_EN
   assign w_force = (r_state == GRANT) && w_owner_req && (r_hold_cnt == HOLD_MAX) && (|w_others);
`else
   assign w_force = 1'b0;
`endif

   // Walk downwards so the last hit is the first set bit after last_ptr.
   always_comb begin
      w_sel = 2'd0;
      if (PRIO_M3 && w_cand[3]) begin
         w_sel = 2'd3;
      end else begin
         for (int k = 4; k >= 1; k--) begin
            if (w_cand[2'(int'(r_last_ptr) + k)]) begin
               w_sel = 2'(int'(r_last_ptr) + k);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_valid_nxt       = r_valid;
      w_onehot_nxt      = r_onehot;
      w_last_ptr_nxt    = r_last_ptr;
      w_hold_cnt_nxt    = r_hold_cnt;
      w_timeout_nxt     = 1'b0;
      w_timeout_cnt_nxt = r_timeout_cnt;

      if ((r_state == GRANT) && w_owner_req && !w_force) begin
         if (r_hold_cnt < HOLD_MAX) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
         end
      end else if (|w_cand) begin
         w_state_nxt    = GRANT;
         w_grant_nxt    = w_sel;
         w_valid_nxt    = 1'b1;
         w_onehot_nxt   = 4'b0001 << w_sel;
         w_last_ptr_nxt = w_sel;
         w_hold_cnt_nxt = 8'd1;
         if (w_force) begin
            w_timeout_nxt = 1'b1;
            if (r_timeout_cnt != 8'hFF) begin
               w_timeout_cnt_nxt = r_timeout_cnt + 8'd1;
            end
         end
      end else begin
         w_state_nxt    = IDLE;
         w_valid_nxt    = 1'b0;
         w_onehot_nxt   = 4'b0000;
         w_hold_cnt_nxt = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_grant       <= 2'd0;
         r_valid       <= 1'b0;
         r_onehot      <= 4'b0000;
         r_last_ptr    <= 2'd3;
         r_hold_cnt    <= 8'd0;
         r_timeout     <= 1'b0;
         r_timeout_cnt <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_valid       <= w_valid_nxt;
         r_onehot      <= w_onehot_nxt;
         r_last_ptr    <= w_last_ptr_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_timeout     <= w_timeout_nxt;
         r_timeout_cnt <= w_timeout_cnt_nxt;
      end
   end

   assign bus.grant_o        = r_grant;
   assign bus.grant_valid_o  = r_valid;
   assign bus.grant_onehot_o = r_onehot;
   assign bus.timeout_o      = r_timeout;
   assign bus.timeout_cnt_o  = r_timeout_cnt;
   // Master 1 alone never stalls the core.
   assign bus.hold_flag_o    = bus.req_i[0] | bus.req_i[2] | bus.req_i[3] |
                               (r_valid & (r_grant != 2'd1));
endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb/tb_rib_rr_arbiter.sv - self-checking bench for rib_rr_arbiter (PRIO_M3=1 and PRIO_M3=0 instances)
module tb_rib_rr_arbiter;
   localparam int MAXH = 4;
`ifdef RIB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   int         n_checks = 0;
   int         n_errors = 0;

   rib_rr_arbiter_if if_p ();
   rib_rr_arbiter_if if_n ();
   assign if_p.req_i = req;
   assign if_n.req_i = req;

   rib_rr_arbiter #(.MAX_HOLD(MAXH), .PRIO_M3(1'b1)) dut_p (.clk(clk), .rst(rst), .bus(if_p.slave));
   rib_rr_arbiter #(.MAX_HOLD(MAXH), .PRIO_M3(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(if_n.slave));

   always #5 clk = ~clk;

   // Model: index 0 is the PRIO_M3=1 instance, index 1 the PRIO_M3=0 instance; owner -1 means idle.
   int m_own[2];
   int m_last[2];
   int m_hold[2];
   int m_tcnt[2];
   bit m_to[2];

   function automatic int pick(logic [3:0] m, int last, bit prio);
      if (prio && m[3]) return 3;
      for (int k = 1; k <= 4; k++) begin
         if (m[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic m_step(int i, bit prio);
      logic [3:0] mk;
      int         nxt;
      int         o;
      o = m_own[i];
      m_to[i] = 1'b0;
      mk = req;
      if (o >= 0 && req[o]) begin
         mk[o] = 1'b0;
         if (!(TO_EN && m_hold[i] == MAXH && mk != 4'b0000)) begin
            if (m_hold[i] < MAXH) m_hold[i]++;
            return;
         end
         m_to[i] = 1'b1;
         if (m_tcnt[i] < 255) m_tcnt[i]++;
      end
      nxt = pick(mk, m_last[i], prio);
      if (nxt < 0) begin
         m_own[i]  = -1;
         m_hold[i] = 0;
      end else begin
         m_own[i]  = nxt;
         m_last[i] = nxt;
         m_hold[i] = 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_own[i]  = -1;
            m_last[i] = 3;
            m_hold[i] = 0;
            m_tcnt[i] = 0;
            m_to[i]   = 1'b0;
         end
      end else begin
         m_step(0, 1'b1);
         m_step(1, 1'b0);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(int i, logic [1:0] g, logic v, logic [3:0] oh, logic hf, logic to, logic [7:0] tc);
      bit ev;
      ev = (m_own[i] >= 0);
      chk($sformatf("i%0d_valid", i), 32'(v), 32'(ev));
      if (ev) chk($sformatf("i%0d_grant", i), 32'(g), 32'(m_own[i]));
      else if (rst) chk($sformatf("i%0d_rst_grant", i), 32'(g), 32'd0);
      chk($sformatf("i%0d_onehot", i), 32'(oh), ev ? (32'd1 << m_own[i]) : 32'd0);
      chk($sformatf("i%0d_hold_flag", i), 32'(hf),
          32'(req[0] | req[2] | req[3] | (ev && m_own[i] != 1)));
      chk($sformatf("i%0d_timeout", i), 32'(to), 32'(m_to[i]));
      chk($sformatf("i%0d_timeout_cnt", i), 32'(tc), 32'(m_tcnt[i]));
   endtask

   always @(negedge clk) begin
      if (rst !== 1'bx) begin
         cmp(0, if_p.grant_o, if_p.grant_valid_o, if_p.grant_onehot_o, if_p.hold_flag_o,
             if_p.timeout_o, if_p.timeout_cnt_o);
         cmp(1, if_n.grant_o, if_n.grant_valid_o, if_n.grant_onehot_o, if_n.hold_flag_o,
             if_n.timeout_o, if_n.timeout_cnt_o);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int held;
      rst = 1'b0;
      req = 4'b0011;
      #1 rst = 1'b1;
      cyc();
      cyc();
      chk("rst_valid", 32'(if_p.grant_valid_o), 32'd0);
      chk("rst_grant", 32'(if_p.grant_o), 32'd0);
      chk("rst_onehot", 32'(if_p.grant_onehot_o), 32'd0);
      chk("rst_timeout", 32'(if_p.timeout_o), 32'd0);
      chk("rst_tcnt", 32'(if_p.timeout_cnt_o), 32'd0);
      rst = 1'b0;

      cyc();
      chk("first_grant_m0", 32'(if_p.grant_o), 32'd0);
      chk("first_valid", 32'(if_p.grant_valid_o), 32'd1);
      chk("first_onehot", 32'(if_p.grant_onehot_o), 32'b0001);
      req = 4'b0010;
      cyc();
      chk("handover_m1", 32'(if_p.grant_o), 32'd1);
      chk("handover_valid", 32'(if_p.grant_valid_o), 32'd1);
      chk("m1_only_no_stall", 32'(if_p.hold_flag_o), 32'd0);

      req = 4'b1010;
      cyc();
      chk("keep_m1_p", 32'(if_p.grant_o), 32'd1);
      chk("keep_m1_n", 32'(if_n.grant_o), 32'd1);
      req = 4'b1000;
      cyc();
      chk("m3_after_drop_p", 32'(if_p.grant_o), 32'd3);
      chk("m3_after_drop_n", 32'(if_n.grant_o), 32'd3);

      req = 4'b0010;
      cyc();
      chk("back_m1_p", 32'(if_p.grant_o), 32'd1);
      req = 4'b1110;
      cyc();
      chk("keep_m1_again_p", 32'(if_p.grant_o), 32'd1);
      req = 4'b1100;
      cyc();
      chk("prio_m3_p", 32'(if_p.grant_o), 32'd3);
      chk("rr_m2_n", 32'(if_n.grant_o), 32'd2);
      req = 4'b1000;
      cyc();
      chk("prio_m3_keep_p", 32'(if_p.grant_o), 32'd3);
      chk("rr_reaches_m3_n", 32'(if_n.grant_o), 32'd3);

      req = 4'b0000;
      cyc();
      chk("idle_valid", 32'(if_p.grant_valid_o), 32'd0);
      chk("idle_no_stall", 32'(if_p.hold_flag_o), 32'd0);
      req = 4'b0010;
      #1 chk("m1_req_no_stall", 32'(if_p.hold_flag_o), 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("m1_grant_no_stall", 32'(if_p.hold_flag_o), 32'd0);
      end
      req = 4'b0100;
      #1 chk("m2_req_stall_same_cycle", 32'(if_p.hold_flag_o), 32'd1);
      cyc();
      chk("m2_grant", 32'(if_p.grant_o), 32'd2);
      req = 4'b0000;
      cyc();
      chk("idle_again", 32'(if_p.grant_valid_o), 32'd0);

      req = 4'b0101;
      cyc();
      chk("hold_m0_first", 32'(if_p.grant_o), 32'd0);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk("hold_m0", 32'(if_p.grant_o), 32'd0);
         chk("hold_m0_no_timeout", 32'(if_p.timeout_o), 32'd0);
      end
`ifdef RIB_ARB_TIMEOUT_EN
      cyc();
      chk("to_switch_m2", 32'(if_p.grant_o), 32'd2);
      chk("to_pulse", 32'(if_p.timeout_o), 32'd1);
      chk("to_cnt", 32'(if_p.timeout_cnt_o), 32'd1);
      cyc();
      chk("to_pulse_end", 32'(if_p.timeout_o), 32'd0);
      chk("to_hold_m2", 32'(if_p.grant_o), 32'd2);
      cyc();
      cyc();
      req = 4'b0001;
      cyc();
      chk("drop_at_limit_m0", 32'(if_p.grant_o), 32'd0);
      chk("drop_at_limit_no_pulse", 32'(if_p.timeout_o), 32'd0);
      chk("drop_at_limit_cnt", 32'(if_p.timeout_cnt_o), 32'd1);
`else
      held = 4;
      for (int k = 0; k < 96; k++) begin
         cyc();
         if (if_p.grant_valid_o === 1'b1 && if_p.grant_o === 2'd0 && if_p.timeout_o === 1'b0) held++;
      end
      chk("hold_m0_100_cycles", 32'(held), 32'd100);
      chk("no_timeout_cnt", 32'(if_p.timeout_cnt_o), 32'd0);
`endif

      #1 rst = 1'b1;
      #1 chk("midgrant_rst_valid_p", 32'(if_p.grant_valid_o), 32'd0);
      chk("midgrant_rst_valid_n", 32'(if_n.grant_valid_o), 32'd0);
      chk("midgrant_rst_onehot", 32'(if_p.grant_onehot_o), 32'd0);
      req = 4'b0110;
      cyc();
      chk("no_grant_in_rst", 32'(if_p.grant_valid_o), 32'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_lowest_p", 32'(if_p.grant_o), 32'd1);
      chk("post_rst_lowest_n", 32'(if_n.grant_o), 32'd1);
      chk("post_rst_valid", 32'(if_p.grant_valid_o), 32'd1);
      chk("post_rst_tcnt", 32'(if_p.timeout_cnt_o), 32'd0);
      req = 4'b0000;
      cyc();
      cyc();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
endmodule
